// File: rtl/mips_run_control.sv
// Run/step/breakpoint controller ahead of the single-cycle MIPS core; produces cpu_step.
// Optional syscall halt is enabled with `define MIPS_RUNCTL_SYSCALL_HALT_EN.
module mips_run_control #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PC_WIDTH        = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_btn_run,
  input  logic                i_btn_step,
  input  logic                i_btn_halt,
  input  logic                i_bp_enable,
  input  logic [PC_WIDTH-1:0] i_bp_addr,
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic [31:0]         i_inst,
  output logic                o_cpu_step,
  output logic                o_running,
  output logic                o_halted,
  output logic [31:0]         o_cycle_count
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_HALT, S_STEP, S_RUN} state_t;

  logic [2:0] w_btn;
  logic [2:0] w_press;
  logic       w_run_p;
  logic       w_step_p;
  logic       w_halt_p;
  logic       w_bp_hit;
  logic       w_stop;

  state_t     r_state;
  logic       r_running;
  logic       r_halted;
  logic       r_stepping;
  logic       r_bp_armed;
  logic [31:0] r_cycle_count;

  assign w_btn = {i_btn_halt, i_btn_step, i_btn_run};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic          r_deb_q;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_deb   <= 1'b0;
        r_deb_q <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= w_btn[g];
        r_sync2 <= r_sync1;
        r_deb_q <= r_deb;
        if (r_sync2 == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_deb <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_press[g] = r_deb & ~r_deb_q;
  end

  assign w_run_p  = w_press[0];
  assign w_step_p = w_press[1];
  assign w_halt_p = w_press[2];

  // Arming delays the compare by one executed instruction so a resume steps off the stop point.
  assign w_bp_hit = i_bp_enable & r_bp_armed & (i_pc == i_bp_addr);

`ifdef MIPS_RUNCTL_SYSCALL_HALT_EN
  logic w_syscall;
  logic w_unused_inst;
  assign w_syscall     = r_bp_armed & (i_inst[31:26] == 6'b000000) & (i_inst[5:0] == 6'h0C);
  assign w_unused_inst = ^i_inst[25:6];
  assign w_stop        = w_halt_p | w_bp_hit | w_syscall;
`else
  logic w_unused_inst;
  assign w_unused_inst = ^i_inst;
  assign w_stop        = w_halt_p | w_bp_hit;
`endif

  assign o_cpu_step = r_stepping | (r_running & ~w_stop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_HALT;
      r_running  <= 1'b0;
      r_halted   <= 1'b1;
      r_stepping <= 1'b0;
      r_bp_armed <= 1'b0;
    end else begin
      case (r_state)
        S_HALT: begin
          if (w_run_p) begin
            r_state    <= S_RUN;
            r_running  <= 1'b1;
            r_halted   <= 1'b0;
            r_bp_armed <= 1'b0;
          end else if (w_step_p) begin
            r_state    <= S_STEP;
            r_stepping <= 1'b1;
            r_halted   <= 1'b0;
          end
        end
        S_STEP: begin
          r_state    <= S_HALT;
          r_stepping <= 1'b0;
          r_halted   <= 1'b1;
        end
        S_RUN: begin
          if (w_stop) begin
            r_state   <= S_HALT;
            r_running <= 1'b0;
            r_halted  <= 1'b1;
          end else begin
            r_bp_armed <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_HALT;
          r_running  <= 1'b0;
          r_halted   <= 1'b1;
          r_stepping <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_count <= '0;
    end else if (o_cpu_step && (r_cycle_count != 32'hFFFF_FFFF)) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign o_running     = r_running;
  assign o_halted      = r_halted;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_mips_run_control.sv
// Directed bench for mips_run_control with DEBOUNCE_CYCLES=4 and a pc-advancing core model.
module tb_mips_run_control;

  localparam int PW = 18;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          btn_run = 1'b0;
  logic          btn_step = 1'b0;
  logic          btn_halt = 1'b0;
  logic          bp_enable = 1'b0;
  logic [PW-1:0] bp_addr = '0;
  logic [PW-1:0] pc;
  logic [31:0]   inst;
  logic          cpu_step;
  logic          running;
  logic          halted;
  logic [31:0]   cycle_count;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mips_run_control #(.DEBOUNCE_CYCLES(4), .PC_WIDTH(PW)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_btn_run    (btn_run),
    .i_btn_step   (btn_step),
    .i_btn_halt   (btn_halt),
    .i_bp_enable  (bp_enable),
    .i_bp_addr    (bp_addr),
    .i_pc         (pc),
    .i_inst       (inst),
    .o_cpu_step   (cpu_step),
    .o_running    (running),
    .o_halted     (halted),
    .o_cycle_count(cycle_count)
  );

  // Core model: pc advances by one instruction on every enabled edge.
  always @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else if (cpu_step) pc <= pc + 18'd4;
  end

  assign inst = (pc == 18'h40) ? 32'h0000_000C : 32'h2008_0001;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_halted(input string tag);
    int n = 0;
    while (!halted && n < 300) begin
      tick();
      n++;
    end
    check(tag, {31'd0, halted}, 32'd1);
  endtask

  logic [31:0] saved_cnt;
  logic [PW-1:0] saved_pc;
  int seen;

  initial begin
    // Reset and idle
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_cpu_step", {31'd0, cpu_step}, 32'd0);
    check("rst_count", cycle_count, 32'd0);

    // Single step: 2 sync + 4 debounce edges, then STEP on the 7th edge
    btn_step = 1'b1;
    repeat (6) tick();
    check("step_not_yet", {31'd0, cpu_step}, 32'd0);
    tick();
    check("step_pulse", {31'd0, cpu_step}, 32'd1);
    check("step_not_halted", {31'd0, halted}, 32'd0);
    tick();
    check("step_one_cycle", {31'd0, cpu_step}, 32'd0);
    check("step_halted", {31'd0, halted}, 32'd1);
    repeat (2) tick();
    btn_step = 1'b0;
    repeat (10) tick();
    check("step_count", cycle_count, 32'd1);
    check("step_pc", {14'd0, pc}, 32'd4);

    // Two-cycle glitch must be filtered
    btn_step = 1'b1;
    repeat (2) tick();
    btn_step = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (cpu_step) seen++;
    end
    check("glitch_no_step", seen, 32'd0);
    check("glitch_count", cycle_count, 32'd1);

    // Reset to restart pc/count from zero
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rst2_count", cycle_count, 32'd0);

    // Run into breakpoint at 0x10
    bp_enable = 1'b1;
    bp_addr   = 18'h00010;
    btn_run   = 1'b1;
    repeat (8) tick();
    btn_run   = 1'b0;
    wait_halted("bp_halt_wait");
    check("bp_pc", {14'd0, pc}, 32'h10);
    check("bp_count", cycle_count, 32'd4);
    check("bp_cpu_step", {31'd0, cpu_step}, 32'd0);
    repeat (10) tick();

    // Resume executes the breakpoint instruction and continues
    btn_run = 1'b1;
    repeat (8) tick();
    btn_run = 1'b0;
    repeat (6) tick();
    check("resume_running", {31'd0, running}, 32'd1);
    check("resume_past_bp", {31'd0, (pc > 18'h10)}, 32'd1);

    // Halt button: cpu_step low in the halt_p cycle itself
    btn_halt = 1'b1;
    repeat (5) tick();
    check("halt_still_running", {31'd0, running}, 32'd1);
    tick();
    check("halt_p_cpu_step", {31'd0, cpu_step}, 32'd0);
    saved_pc = pc;
    tick();
    check("halt_state", {31'd0, halted}, 32'd1);
    check("halt_pc_frozen", {14'd0, pc}, {14'd0, saved_pc});
    check("halt_count_vs_pc", cycle_count, {16'd0, pc[PW-1:2]});
    saved_cnt = cycle_count;
    btn_halt = 1'b0;
    repeat (10) tick();
    check("halt_count_frozen", cycle_count, saved_cnt);

    // Run and step together: run wins
    btn_run  = 1'b1;
    btn_step = 1'b1;
    repeat (8) tick();
    btn_run  = 1'b0;
    btn_step = 1'b0;
    check("both_running", {31'd0, running}, 32'd1);
    check("both_not_halted", {31'd0, halted}, 32'd0);
    repeat (8) tick();

    // Reset mid-RUN takes effect without a clock edge
    reset = 1'b1;
    #1;
    check("midrst_cpu_step", {31'd0, cpu_step}, 32'd0);
    check("midrst_running", {31'd0, running}, 32'd0);
    check("midrst_halted", {31'd0, halted}, 32'd1);
    check("midrst_count", cycle_count, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) tick();

    // Syscall at pc 0x40
    bp_enable = 1'b0;
    btn_run = 1'b1;
    repeat (8) tick();
    btn_run = 1'b0;
`ifdef MIPS_RUNCTL_SYSCALL_HALT_EN
    wait_halted("sys_halt_wait");
    check("sys_pc", {14'd0, pc}, 32'h40);
    check("sys_count", cycle_count, 32'd16);
    repeat (10) tick();
    btn_run = 1'b1;
    repeat (8) tick();
    btn_run = 1'b0;
    repeat (4) tick();
    check("sys_resume_running", {31'd0, running}, 32'd1);
    check("sys_resume_past", {31'd0, (pc > 18'h40)}, 32'd1);
    check("sys_resume_count", cycle_count, {16'd0, pc[PW-1:2]});
`else
    begin
      int n = 0;
      while (pc <= 18'h60 && n < 300) begin
        tick();
        n++;
      end
    end
    check("nosys_running", {31'd0, running}, 32'd1);
    check("nosys_past", {31'd0, (pc > 18'h60)}, 32'd1);
    check("nosys_count", cycle_count, {16'd0, pc[PW-1:2]});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mips_run_control.md
Name: mips_run_control

Overview:
- Run/step controller directly upstream of the single-cycle MIPS core.
- Produces the one-cycle-per-instruction execute enable (cpu_step) that gates the core's PC and register/memory writes.
- Watches the core's PC and current instruction to stop on a PC breakpoint.
- Takes raw board push-buttons (run, step, halt) and exposes status plus an executed-instruction counter.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive identical synchronized samples required before a button's debounced level changes (minimum 1).
- PC_WIDTH, 18: width of the pc and bp_addr buses.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_run  input  1  raw run button, asynchronous, active-high
- btn_step  input  1  raw single-step button, asynchronous, active-high
- btn_halt  input  1  raw halt button, asynchronous, active-high
- bp_enable  input  1  breakpoint compare enable (synchronous level)
- bp_addr  input  PC_WIDTH  breakpoint PC value
- pc  input  PC_WIDTH  core's current PC
- inst  input  32  core's current instruction word
- cpu_step  output  1  core executes the current instruction on this clock edge when high
- running  output  1  FSM is in RUN
- halted  output  1  FSM is in HALT
- cycle_count  output  32  number of cycles with cpu_step high

Behaviour:
- Reset (asynchronous, active-high) sets:
  - FSM state = HALT, so halted=1, running=0, cpu_step=0.
  - cycle_count=0, bp_armed=0.
  - Synchronizers, debounced levels and debounce counters = 0.
- Input conditioning, per button:
  - 2-FF synchronizer, then debouncer.
  - Debounce counter clears whenever the synchronized sample equals the debounced level.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1 the debounced level takes the sample and the counter clears.
  - A rising-edge detect on the debounced level gives a 1-cycle press pulse: run_p, step_p, halt_p.
  - Press-to-pulse latency = 2 + DEBOUNCE_CYCLES cycles.
- FSM states: HALT, STEP, RUN. The FSM is registered and acts on press pulses.
- HALT:
  - cpu_step=0.
  - run_p -> RUN and clears bp_armed.
  - Otherwise step_p -> STEP.
  - run_p and step_p in the same cycle: run wins.
  - halt_p is ignored.
- STEP:
  - cpu_step=1 for exactly one cycle; unconditionally -> HALT next cycle.
  - Breakpoint and button pulses are ignored in STEP.
- RUN: combinational cpu_step = NOT stop, where stop = halt_p OR bp_hit.
  - bp_hit = bp_enable AND bp_armed AND (pc == bp_addr).
  - stop -> HALT; cpu_step=0 that cycle, so the instruction at pc is not executed.
  - Otherwise stay in RUN.
  - halt_p has priority over bp_hit; both give the same result. run_p and step_p are ignored.
- bp_armed re-arm rule:
  - bp_armed <= 1 on every cycle in RUN with cpu_step=1.
  - bp_armed <= 0 on entering RUN.
  - Effect: resuming from a breakpoint executes the breakpoint instruction once before the compare is live again.
- cycle_count:
  - Increments by 1 on each clock edge with cpu_step=1.
  - Saturates at 32'hFFFFFFFF (no wrap).
  - Cleared only by reset.
- Reset mid-RUN or mid-STEP: immediate return to HALT; cpu_step drops asynchronously.
- pc and inst are sampled only combinationally. No latency is added to the core path: cpu_step is valid in the same cycle as pc.

Optional Feature:
- Macro: MIPS_RUNCTL_SYSCALL_HALT_EN.
- Defined:
  - In RUN, stop additionally includes syscall detection: inst[31:26]==6'b000000 and inst[5:0]==6'h0C.
  - On detection, cpu_step=0 and -> HALT. The syscall is not executed and cycle_count is not incremented.
  - Resume rule: the syscall check is qualified by bp_armed, exactly like the breakpoint. Run resumes past it; step executes it.
- Undefined: syscall is treated as an ordinary instruction; no detection logic is present.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then idle 20 cycles -> halted=1, running=0, cpu_step=0, cycle_count=0.
- btn_step held 10 cycles -> after 6 cycles cpu_step high exactly 1 cycle; halted=1 again; cycle_count=1. A 2-cycle glitch on btn_step gives no step.
- btn_run pulse, bp_enable=1, bp_addr=18'h00010, pc advancing by 4 per step -> cpu_step high for pc=0..0xC, low at pc=0x10; halted=1; cycle_count=4. Second run press executes 0x10 and continues.
- In RUN, press btn_halt -> cpu_step low from the halt_p cycle; state HALT; cycle_count frozen. btn_run and btn_step pressed together while halted -> RUN.
- Assert reset for 1 cycle mid-RUN -> cpu_step, running and cycle_count go to 0 immediately, halted=1.
- With MIPS_RUNCTL_SYSCALL_HALT_EN, run into inst=32'h0000000C -> halt before executing it; run again executes it once. Without the macro -> no stop.
